// File: rtl/vga_demo_scheduler.sv
// Raster timing generator and demo scene scheduler for the VGA demo datapath.
// Configuration commands are taken in via valid/ready and only take effect at a frame boundary.
module vga_demo_scheduler #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int NUM_SCENES  = 4,
  parameter int DEFAULT_FPS = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_cmd,
  input  logic [7:0]                    cfg_data,
  output logic                          vga_h_sync,
  output logic                          vga_v_sync,
  output logic                          pix_active,
  output logic [9:0]                    pix_x,
  output logic [9:0]                    pix_y,
  output logic [$clog2(NUM_SCENES)-1:0] scene,
  output logic                          frame_start,
  output logic                          paused,
  output logic                          dbg_cmd_state
);

  localparam int SW      = $clog2(NUM_SCENES);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0] FPS_RST = 8'(DEFAULT_FPS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [1:0] CMD_FPS    = 2'd0;
  localparam logic [1:0] CMD_SCENE  = 2'd1;
  localparam logic [1:0] CMD_PAUSE  = 2'd2;
  localparam logic [1:0] CMD_RESUME = 2'd3;

  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [0:0]    state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic [SW-1:0] scene_q, scene_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [7:0]    fps_q, fps_d;
  logic          paused_q, paused_d;
  logic          frame_end;

  assign frame_end = (h_q == H_MAX) && (v_q == V_MAX);

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = '0;
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  // Handshake: a command transfers on any cycle with cfg_valid && cfg_ready;
  // cfg_ready stays low from then until the frame_end that applies it.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    scene_d  = scene_q;
    fcnt_d   = fcnt_q;
    fps_d    = fps_q;
    paused_d = paused_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          cmd_d   = cfg_cmd;
          data_d  = cfg_data;
          state_d = ST_PEND;
        end
      end
      default: begin
        if (frame_end) state_d = ST_IDLE;
      end
    endcase
    // An applied command always wins over auto-advance for that frame.
    if (frame_end && state_q == ST_PEND) begin
      case (cmd_q)
        CMD_FPS: begin
          fps_d  = data_q;
          fcnt_d = '0;
        end
        CMD_SCENE: begin
          scene_d = data_q[SW-1:0];
          fcnt_d  = '0;
        end
        CMD_PAUSE:  paused_d = 1'b1;
        default:    paused_d = 1'b0;
      endcase
    end else if (frame_end && !paused_q && fps_q != 8'd0) begin
      if (fcnt_q == fps_q - 8'd1) begin
        scene_d = scene_q + SW'(1);
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      data_q   <= '0;
      scene_q  <= '0;
      fcnt_q   <= '0;
      fps_q    <= FPS_RST;
      paused_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      scene_q  <= scene_d;
      fcnt_q   <= fcnt_d;
      fps_q    <= fps_d;
      paused_q <= paused_d;
    end
  end

  assign pix_x         = h_q;
  assign pix_y         = v_q;
  assign pix_active    = (h_q < H_VIS) && (v_q < V_VIS);
  assign vga_h_sync    = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vga_v_sync    = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign frame_start   = (h_q == 10'd0) && (v_q == 10'd0);
  assign scene         = scene_q;
  assign paused        = paused_q;
  assign cfg_ready     = (state_q == ST_IDLE);
  assign dbg_cmd_state = state_q;

endmodule

// File: tb/tb_vga_demo_scheduler.sv
// Directed bench for vga_demo_scheduler on a shrunken 16x10 raster so that
// scene sequencing over many frames stays short.
module tb_vga_demo_scheduler;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int NS = 4, DFPS = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_cmd;
  logic [7:0] cfg_data;
  logic       vga_h_sync, vga_v_sync, pix_active;
  logic [9:0] pix_x, pix_y;
  logic [1:0] scene;
  logic       frame_start, paused, dbg_cmd_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ex_h = 0;
  int ex_v = 0;

  vga_demo_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_SCENES(NS), .DEFAULT_FPS(DFPS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_cmd(cfg_cmd),
    .cfg_data(cfg_data),
    .vga_h_sync(vga_h_sync),
    .vga_v_sync(vga_v_sync),
    .pix_active(pix_active),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .scene(scene),
    .frame_start(frame_start),
    .paused(paused),
    .dbg_cmd_state(dbg_cmd_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock; the raster position model follows the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      ex_h = 0;
      ex_v = 0;
    end else if (ex_h == HT - 1) begin
      ex_h = 0;
      ex_v = (ex_v == VT - 1) ? 0 : ex_v + 1;
    end else begin
      ex_h = ex_h + 1;
    end
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(ex_h == h && ex_v == v) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("goto_reached", (ex_h == h && ex_v == v), 1);
  endtask

  task automatic next_frame();
    tick();
    goto(0, 0);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] data);
    cfg_valid = 1'b1;
    cfg_cmd   = cmd;
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_cmd   = 2'd0;
    cfg_data  = 8'd0;
    tick(); tick(); tick();
    reset = 1'b0;

    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_frame_start", frame_start, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_scene", scene, 0);
    check("rst_paused", paused, 0);
    check("rst_pix_active", pix_active, 1);
    check("rst_hsync", vga_h_sync, 1);
    check("rst_vsync", vga_v_sync, 1);

    // Full-frame scan of raster outputs against the position model.
    for (int i = 0; i < FRAME; i++) begin
      check("scan_x", pix_x, ex_h);
      check("scan_y", pix_y, ex_v);
      check("scan_active", pix_active, (ex_h < HA) && (ex_v < VA));
      check("scan_hsync", vga_h_sync, !((ex_h >= HA + HF) && (ex_h < HA + HF + HS)));
      check("scan_vsync", vga_v_sync, !((ex_v >= VA + VF) && (ex_v < VA + VF + VS)));
      check("scan_fstart", frame_start, (ex_h == 0) && (ex_v == 0));
      tick();
    end
    check("f1_fstart", frame_start, 1);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!frame_start && cnt < 2 * FRAME);
    check("fstart_period", cnt, FRAME);
    goto(0, 0);

    // Default frames-per-scene: first advance lands at the start of frame 3.
    goto(HT - 1, VT - 1);
    check("dflt_pre_adv", scene, 0);
    tick();
    check("dflt_adv", scene, 1);

    // Set fps=2 mid-frame 3.
    goto(5, 3);
    send(2'd0, 8'd2);
    check("fps_ready_low", cfg_ready, 0);
    check("fps_dbg_pend", dbg_cmd_state, 1);
    goto(HT - 1, VT - 1);
    check("fps_ready_fe", cfg_ready, 0);
    tick();
    check("fps_ready_back", cfg_ready, 1);
    check("fps_f4_scene", scene, 1);
    next_frame();
    check("fps_f5_scene", scene, 1);
    next_frame();
    check("fps_f6_scene", scene, 2);
    next_frame();
    check("fps_f7_scene", scene, 2);
    next_frame();
    check("fps_f8_scene", scene, 3);
    next_frame();
    next_frame();
    check("fps_f10_wrap", scene, 0);

    // Force scene accepted on the frame_end cycle of frame 10.
    goto(HT - 1, VT - 1);
    send(2'd1, 8'h07);
    check("force_ready_low", cfg_ready, 0);
    check("force_f11_scene", scene, 0);
    next_frame();
    check("force_f12_scene", scene, 3);
    check("force_ready_back", cfg_ready, 1);
    next_frame();
    check("force_f13_scene", scene, 3);
    next_frame();
    check("force_f14_scene", scene, 0);

    // Pause, with a second offer while pending that must be dropped.
    goto(4, 2);
    send(2'd2, 8'd0);
    send(2'd1, 8'd2);
    check("pause_ready_low", cfg_ready, 0);
    next_frame();
    check("pause_paused", paused, 1);
    check("pause_f15_scene", scene, 0);
    check("pause_ready_back", cfg_ready, 1);
    for (int k = 0; k < 5; k++) begin
      next_frame();
      check("pause_frozen", scene, 0);
    end
    goto(3, 3);
    send(2'd0, 8'd1);
    next_frame();
    check("fps1_scene", scene, 0);
    check("fps1_paused", paused, 1);
    goto(3, 3);
    send(2'd3, 8'd0);
    next_frame();
    check("resume_paused", paused, 0);
    check("resume_scene", scene, 0);
    next_frame();
    check("resume_adv1", scene, 1);
    next_frame();
    check("resume_adv2", scene, 2);

    // fps=0 holds the scene.
    goto(3, 3);
    send(2'd0, 8'd0);
    next_frame();
    check("fps0_apply", scene, 2);
    next_frame();
    check("fps0_hold1", scene, 2);
    next_frame();
    check("fps0_hold2", scene, 2);

    // Reset mid-frame with a command pending.
    goto(7, 4);
    send(2'd1, 8'd1);
    check("mrst_pending", cfg_ready, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_pix_x", pix_x, 0);
    check("mrst_pix_y", pix_y, 0);
    check("mrst_scene", scene, 0);
    check("mrst_ready", cfg_ready, 1);
    check("mrst_paused", paused, 0);
    check("mrst_fstart", frame_start, 1);
    next_frame();
    check("mrst_f1_scene", scene, 0);
    next_frame();
    check("mrst_f2_scene", scene, 0);
    next_frame();
    check("mrst_f3_scene", scene, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
